// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter and its lane aligner:
// access-size encodings, FSM states, requester identifiers and width defaults.
package dmem_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 10;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_RMW_WR = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  // An access is rejected when the size is reserved or the byte offset
  // is not naturally aligned for the requested size.
  function automatic logic access_err(input size_e size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return offset[0];
      SZ_WORD: return (offset != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Purely combinational byte-lane logic for a little-endian 32-bit word:
// extracts and sign/zero-extends a sub-word for loads, and merges a
// right-aligned sub-word into an existing word for stores.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [DW_DEF-1:0] word_i,
  input  logic [1:0]        offset_i,
  input  size_e             size_i,
  input  logic              signed_i,
  input  logic [DW_DEF-1:0] wdata_i,
  output logic [DW_DEF-1:0] load_o,
  output logic [DW_DEF-1:0] store_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [4:0]  lane_lsb;

  assign lane_lsb = {offset_i, 3'b000};
  assign byte_sel = word_i[lane_lsb +: 8];
  assign half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];

  // Load path: pick the addressed lane and extend it to a full word.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    load_o = '0;
    case (size_i)
      SZ_BYTE: load_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_o = {{16{signed_i & half_sel[15]}}, half_sel};
      SZ_WORD: load_o = word_i;
      default: load_o = '0;
    endcase
  end

  // Store path: replace only the addressed lane of the old word.
  always_comb begin
    store_o = word_i;
    case (size_i)
      SZ_BYTE: store_o[lane_lsb +: 8] = wdata_i[7:0];
      SZ_HALF: begin
        if (offset_i[1]) store_o[31:16] = wdata_i[15:0];
        else             store_o[15:0]  = wdata_i[15:0];
      end
      SZ_WORD: store_o = wdata_i;
      default: store_o = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter_ctrl.sv
// Two-port arbiter and sequencer for the single-ported data memory.
// Requester A (pipeline MEM stage) and B (debug/loader) are arbitrated
// round-robin on contention; sub-word stores become read-modify-write.
// Every output is registered: each output's next value is decoded from the
// next FSM state so it is valid during the cycle that state is occupied.
module dmem_arbiter_ctrl
  import dmem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [1:0]    a_size,
  input  logic          a_signed,
  input  logic [AW+1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [1:0]    b_size,
  input  logic          b_signed,
  input  logic [AW+1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  // Latched copy of the accepted request; request inputs are ignored
  // until the transaction completes.
  typedef struct packed {
    port_e         port;
    size_e         size;
    logic          sgn;
    logic [AW-1:0] widx;
    logic [1:0]    off;
    logic [DW-1:0] wdata;
  } op_t;

  state_e        state_q, state_d;
  port_e         rr_last_q, rr_last_d;
  op_t           op_q, op_d;

  logic          a_ack_q, a_ack_d;
  logic          b_ack_q, b_ack_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_din_q, mem_din_d;

  // Winner selection: B wins if alone, or on contention when A won last.
  logic          grant_b;
  logic          sel_we;
  size_e         sel_size;
  logic          sel_signed;
  logic [AW+1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_err;

  assign grant_b    = b_req & (~a_req | (rr_last_q == PORT_A));
  assign sel_we     = grant_b ? b_we     : a_we;
  assign sel_size   = size_e'(grant_b ? b_size : a_size);
  assign sel_signed = grant_b ? b_signed : a_signed;
  assign sel_addr   = grant_b ? b_addr   : a_addr;
  assign sel_wdata  = grant_b ? b_wdata  : a_wdata;
  assign sel_err    = access_err(sel_size, sel_addr[1:0]);

  // Lane logic works on the raw memory output so load data and merged store
  // data are ready at the edge that ends RD / RMW_RD.
  logic [DW-1:0] load_data;
  logic [DW-1:0] merged_word;

  dmem_lane_align u_lane_align (
    .word_i   (mem_dout),
    .offset_i (op_q.off),
    .size_i   (op_q.size),
    .signed_i (op_q.sgn),
    .wdata_i  (op_q.wdata),
    .load_o   (load_data),
    .store_o  (merged_word)
  );

  // State, op and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_last_q   <= PORT_B;
      op_q        <= '0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      op_q        <= op_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    op_d        = op_q;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = '0;
    mem_din_d   = '0;

    case (state_q)
      ST_IDLE: begin
        if (a_req | b_req) begin
          op_d.port  = grant_b ? PORT_B : PORT_A;
          op_d.size  = sel_size;
          op_d.sgn   = sel_signed;
          op_d.widx  = sel_addr[AW+1:2];
          op_d.off   = sel_addr[1:0];
          op_d.wdata = sel_wdata;
          if (a_req & b_req) rr_last_d = grant_b ? PORT_B : PORT_A;

          if (sel_err) begin
            state_d   = ST_DONE;
            rsp_err_d = 1'b1;
          end else if (!sel_we) begin
            state_d    = ST_RD;
            mem_read_d = 1'b1;
            mem_addr_d = sel_addr[AW+1:2];
          end else if (sel_size == SZ_WORD) begin
            state_d     = ST_RMW_WR;
            mem_write_d = 1'b1;
            mem_addr_d  = sel_addr[AW+1:2];
            mem_din_d   = sel_wdata;
          end else begin
            state_d    = ST_RMW_RD;
            mem_read_d = 1'b1;
            mem_addr_d = sel_addr[AW+1:2];
          end
        end
      end
      ST_RD: begin
        state_d     = ST_DONE;
        rsp_rdata_d = load_data;
      end
      ST_RMW_RD: begin
        state_d     = ST_RMW_WR;
        mem_write_d = 1'b1;
        mem_addr_d  = op_q.widx;
        mem_din_d   = merged_word;
      end
      ST_RMW_WR: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (state_d == ST_DONE) begin
      a_ack_d = (op_d.port == PORT_A);
      b_ack_d = (op_d.port == PORT_B);
    end
  end

  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;

endmodule
